avmm_cmd_master: RTL and testbench
==================================

Name: avmm_cmd_master

Overview:
- Avalon-MM initiator (master) that issues single-beat reads and writes to PIO-style Avalon-MM slaves: chipselect, active-low write_n/read_n, word address.
- Accepts one command at a time on a valid/ready command port and returns exactly one response per command.
- Sits between a test sequencer or soft controller and the register slaves in the Qsys fabric.
- Handles slave read latency and, optionally, waitrequest with a timeout.

Parameters:
- ADDR_W, 2, width of cmd_address and avm_address (word address).
- DATA_W, 32, width of all data paths.
- READ_LATENCY, 0, slave read latency in cycles (0..7); 0 = readdata valid in the strobe cycle.
- TIMEOUT_CYCLES, 255, max consecutive waitrequest-high cycles before abort (only with AVM_WAITREQUEST_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target word address.
- cmd_writedata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_readdata  out  DATA_W  read result; 0 for writes and errors.
- rsp_error  out  1  access aborted by timeout.
- avm_address  out  ADDR_W  Avalon address.
- avm_chipselect  out  1  Avalon chipselect.
- avm_write_n  out  1  Avalon write strobe, active low.
- avm_read_n  out  1  Avalon read strobe, active low.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_waitrequest  in  1  slave stall; port present only with AVM_WAITREQUEST_EN.

Behaviour:
- Reset state:
  - state = IDLE; cmd_ready = 1.
  - avm_chipselect = 0; avm_write_n = 1; avm_read_n = 1.
  - avm_address = 0; avm_writedata = 0.
  - rsp_valid = 0; rsp_readdata = 0; rsp_error = 0.
- All avm_* and rsp_* outputs are registered. cmd_ready is decoded from the state register (1 only in IDLE).
- States: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE:
  - On a clock edge with cmd_valid && cmd_ready, latch address, data and direction, and enter ACCESS.
  - The avm strobes go active in the next cycle (1 cycle from accept to strobe).
- ACCESS:
  - avm_chipselect = 1.
  - avm_write_n = 0 for writes; avm_read_n = 0 for reads.
  - address and writedata held stable.
  - The transfer completes at the first edge where waitrequest is low (always the first edge without the feature). At that edge all strobes deassert.
  - Write: go to RESP.
  - Read, READ_LATENCY = 0: capture avm_readdata at that edge and go to RESP.
  - Read, READ_LATENCY = N > 0: go to WAIT_RD.
- WAIT_RD:
  - A 3-bit counter loads at completion.
  - avm_readdata is captured at the Nth edge after the completion edge, then the block goes to RESP.
  - Strobes stay deasserted throughout.
- RESP:
  - rsp_valid = 1 for exactly one cycle; there is no response backpressure.
  - Next state is IDLE.
  - rsp_readdata and rsp_error hold their values until the next response.
- Throughput, READ_LATENCY = 0, no stalls: one command per 3 cycles (accept, strobe, resp).
- Commands presented outside IDLE are ignored. A cmd_valid held high is accepted once per IDLE visit.
- Writes always return rsp_readdata = 0 and rsp_error = 0.
- Reset asserted in any state returns the block to IDLE at that edge:
  - strobes deasserted;
  - pending command dropped;
  - no rsp_valid issued.
- Reset has priority over every other event, including cmd_valid in the same cycle.

Optional Feature:
- AVM_WAITREQUEST_EN defined:
  - The avm_waitrequest port exists.
  - ACCESS is held while waitrequest = 1.
  - An 8-bit stall counter increments on each waitrequest-high cycle and clears on entry to ACCESS.
  - When the counter reaches TIMEOUT_CYCLES, strobes deassert at the next edge, the block enters RESP with rsp_error = 1 and rsp_readdata = 0, and WAIT_RD is skipped.
- AVM_WAITREQUEST_EN not defined:
  - The avm_waitrequest port and the counter are absent.
  - Every access completes after exactly one strobe cycle.
  - rsp_error is tied to 0.

Test Plan:
- Reset held 2 cycles with cmd_valid = 1 -> chipselect = 0, write_n = 1, read_n = 1, rsp_valid = 0, cmd_ready = 1; no access issued.
- Write 0xDEADBEEF to addr 0 on a PIO slave model -> exactly 1 cycle of chipselect = 1, write_n = 0, address = 0, writedata = 0xDEADBEEF, starting 1 cycle after accept; rsp_valid 1 cycle later with readdata = 0 and error = 0; slave out_port = 0xDEADBEEF.
- Read addr 0 then read addr 1 after that write -> rsp_readdata = 0xDEADBEEF, then 0x00000000; exactly one rsp_valid per command; cmd_valid held high is not double-accepted.
- READ_LATENCY = 2 build, slave returning 0x12345678 two cycles after the strobe -> rsp_valid exactly 2 cycles later than in the latency-0 build; rsp_readdata = 0x12345678.
- AVM_WAITREQUEST_EN, TIMEOUT_CYCLES = 8:
  - waitrequest high for 3 cycles -> strobes held 4 cycles; single good response.
  - waitrequest stuck high -> strobes drop after 8 stall cycles; rsp_error = 1 and rsp_readdata = 0.
- Reset asserted during ACCESS -> strobes deasserted at the next edge; no rsp_valid; cmd_ready = 1 the cycle after reset releases.

Source files
------------

// File: rtl/avmm_cmd_master.sv
// Single-beat Avalon-MM initiator fed by a valid/ready command port, one response per command.
// Define AVM_WAITREQUEST_EN to add the avm_waitrequest port and the stall timeout.
module avmm_cmd_master #(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
`ifdef AVM_WAITREQUEST_EN
  input  logic              avm_waitrequest,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE, and rsp_valid is a one-cycle strobe with no backpressure.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT_RD = 2'd2, RESP = 2'd3} state_e;

  localparam logic [2:0] LAT_LOAD = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cs_q, cs_d;
  logic                write_n_q, write_n_d;
  logic                read_n_q, read_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic [2:0]          lat_q, lat_d;
  logic                stall, abort;

`ifdef AVM_WAITREQUEST_EN
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] stall_cnt_q, stall_cnt_d;
  // Abort on the edge that would take the stall count to TIMEOUT_CYCLES.
  assign stall = avm_waitrequest;
  assign abort = avm_waitrequest && (stall_cnt_q == STALL_LAST);
`else
  assign stall = 1'b0;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cs_d        = cs_q;
    write_n_d   = write_n_q;
    read_n_d    = read_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    lat_d       = lat_q;
`ifdef AVM_WAITREQUEST_EN
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d      = cmd_write;
          addr_d    = cmd_address;
          wdata_d   = cmd_writedata;
          cs_d      = 1'b1;
          write_n_d = ~cmd_write;
          read_n_d  = cmd_write;
`ifdef AVM_WAITREQUEST_EN
          stall_cnt_d = 8'd0;
`endif
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (abort) begin
          cs_d        = 1'b0;
          write_n_d   = 1'b1;
          read_n_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end else if (stall) begin
`ifdef AVM_WAITREQUEST_EN
          stall_cnt_d = stall_cnt_q + 8'd1;
`endif
        end else begin
          cs_d      = 1'b0;
          write_n_d = 1'b1;
          read_n_d  = 1'b1;
          if (wr_q || READ_LATENCY == 0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = wr_q ? '0 : avm_readdata;
            rsp_error_d = 1'b0;
            state_d     = RESP;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (lat_q == 3'd0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = avm_readdata;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      lat_q       <= 3'd0;
`ifdef AVM_WAITREQUEST_EN
      stall_cnt_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      lat_q       <= lat_d;
`ifdef AVM_WAITREQUEST_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_readdata   = rsp_data_q;
  assign rsp_error      = rsp_error_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_read_n     = read_n_q;
  assign avm_writedata  = wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: latency-0 and latency-2 instances side by side, each with a PIO slave.
module tb_avmm_cmd_master;

`ifdef AVM_WAITREQUEST_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic        rsp_error [2];
  logic [31:0] rsp_readdata [2];
  logic [1:0]  avm_address [2];
  logic        avm_chipselect [2];
  logic        avm_write_n [2];
  logic        avm_read_n [2];
  logic [31:0] avm_writedata [2];
  logic [31:0] avm_readdata [2];
  logic        avm_waitrequest [2];
  logic [1:0]  dbg_state [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    avmm_cmd_master #(
      .ADDR_W(2), .DATA_W(32), .READ_LATENCY(2 * k), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[k]), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rsp_valid[k]), .rsp_readdata(rsp_readdata[k]), .rsp_error(rsp_error[k]),
      .avm_address(avm_address[k]), .avm_chipselect(avm_chipselect[k]),
      .avm_write_n(avm_write_n[k]), .avm_read_n(avm_read_n[k]),
      .avm_writedata(avm_writedata[k]), .avm_readdata(avm_readdata[k]),
`ifdef AVM_WAITREQUEST_EN
      .avm_waitrequest(avm_waitrequest[k]),
`endif
      .dbg_state(dbg_state[k])
    );
  end

  // PIO slaves: instance 0 answers combinationally, instance 1 two edges after the read strobe.
  logic [31:0] slv_mem [2][4];
  logic [31:0] rd_p0, rd_p1;
  int          wait_cnt [2];
  int          stall_cfg;
  localparam logic [31:0] JUNK = 32'hBAD0_0000;

  initial begin
    for (int k = 0; k < 2; k++) begin
      wait_cnt[k] = 0;
      for (int a = 0; a < 4; a++) slv_mem[k][a] = 32'd0;
    end
    rd_p0 = JUNK;
    rd_p1 = JUNK;
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      avm_waitrequest[k] = avm_chipselect[k] && (wait_cnt[k] < stall_cfg);
    avm_readdata[0] = avm_read_n[0] ? JUNK : slv_mem[0][avm_address[0]];
    avm_readdata[1] = rd_p1;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      wait_cnt[k] <= avm_chipselect[k] ? wait_cnt[k] + 1 : 0;
      if (avm_chipselect[k] && !avm_waitrequest[k] && !avm_write_n[k])
        slv_mem[k][avm_address[k]] <= avm_writedata[k];
    end
    rd_p0 <= (avm_chipselect[1] && !avm_waitrequest[1] && !avm_read_n[1]) ?
             slv_mem[1][avm_address[1]] : JUNK;
    rd_p1 <= rd_p0;
  end

  // bus/response monitor, sampled on the falling edge
  int          t0;
  int          strobe_cyc [2], strobe_starts [2], first_strobe [2], strobe_bad [2];
  int          rsp_cnt [2], rsp_lat [2];
  logic [31:0] rsp_data [2];
  logic        rsp_err [2];
  logic        cs_prev [2];
  logic        cur_wr;
  logic [1:0]  cur_addr;
  logic [31:0] cur_data;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (avm_chipselect[k] === 1'b1) begin
        if (cs_prev[k] !== 1'b1) begin
          strobe_starts[k]++;
          if (strobe_starts[k] == 1) first_strobe[k] = cyc - t0;
        end
        strobe_cyc[k]++;
        if (avm_address[k] !== cur_addr || avm_write_n[k] !== !cur_wr ||
            avm_read_n[k] !== cur_wr || (cur_wr && avm_writedata[k] !== cur_data))
          strobe_bad[k]++;
      end else if (avm_write_n[k] !== 1'b1 || avm_read_n[k] !== 1'b1) begin
        strobe_bad[k]++;
      end
      cs_prev[k] = avm_chipselect[k];
      if (rsp_valid[k] === 1'b1) begin
        rsp_cnt[k]++;
        rsp_lat[k]  = cyc - t0;
        rsp_data[k] = rsp_readdata[k];
        rsp_err[k]  = rsp_error[k];
      end
    end
  end

  // scoreboard
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [4];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      strobe_cyc[k] = 0; strobe_starts[k] = 0; first_strobe[k] = -1; strobe_bad[k] = 0;
      rsp_cnt[k] = 0; rsp_lat[k] = -1; rsp_data[k] = JUNK; rsp_err[k] = 1'bx;
    end
  endtask

  // driver: one command, optionally with cmd_valid left high while the block is busy
  task automatic run_cmd(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                         input logic hold, input int stall_in, input string tag);
    int   stall, exp_strobe, exp_lat;
    logic tmo;
    stall = stall_in;
`ifndef AVM_WAITREQUEST_EN
    stall = 0;
`endif
    @(negedge clk);
    stall_cfg = stall;
    clear_stats();
    for (int k = 0; k < 2; k++) check($sformatf("%s/d%0d/ready", tag, k), cmd_ready[k], 1'b1);
    cur_wr = wr; cur_addr = addr; cur_data = data; t0 = cyc;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_writedata = data;

    tmo = 1'b0;
    exp_strobe = 1;
`ifdef AVM_WAITREQUEST_EN
    if (stall >= TMO) begin tmo = 1'b1; exp_strobe = TMO; end
    else exp_strobe = stall + 1;
`endif
    exp_q.push_back((wr || tmo) ? 32'd0 : ref_mem[addr]);

    repeat (hold ? 3 : 1) @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_address = 2'($urandom);
    cmd_writedata = $urandom;
    for (int n = 0; n < 300 && !(rsp_cnt[0] >= 1 && rsp_cnt[1] >= 1); n++) @(posedge clk);
    repeat (6) @(posedge clk);

    if (wr && !tmo) ref_mem[addr] = data;
    for (int k = 0; k < 2; k++) begin
      exp_lat = 1 + exp_strobe + ((!wr && !tmo) ? 2 * k : 0);
      check($sformatf("%s/d%0d/rsp_cnt", tag, k), rsp_cnt[k], 1);
      check($sformatf("%s/d%0d/rsp_lat", tag, k), rsp_lat[k], exp_lat);
      check($sformatf("%s/d%0d/rdata", tag, k), rsp_data[k], exp_q[0]);
      check($sformatf("%s/d%0d/err", tag, k), rsp_err[k], tmo);
      check($sformatf("%s/d%0d/strobe_cyc", tag, k), strobe_cyc[k], exp_strobe);
      check($sformatf("%s/d%0d/accesses", tag, k), strobe_starts[k], 1);
      check($sformatf("%s/d%0d/strobe_start", tag, k), first_strobe[k], 1);
      check($sformatf("%s/d%0d/strobe_fields", tag, k), strobe_bad[k], 0);
      check($sformatf("%s/d%0d/slave_mem", tag, k), slv_mem[k][addr], ref_mem[addr]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4; a++) ref_mem[a] = 32'd0;
    stall_cfg = 0; t0 = 0;
    cur_wr = 1'b0; cur_addr = 2'd0; cur_data = 32'd0;
    clear_stats();
    for (int k = 0; k < 2; k++) cs_prev[k] = 1'b0;

    // reset held two edges with a command pending
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_address = 2'd3; cmd_writedata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst/d%0d/ready", k), cmd_ready[k], 1'b1);
      check($sformatf("rst/d%0d/cs", k), avm_chipselect[k], 1'b0);
      check($sformatf("rst/d%0d/write_n", k), avm_write_n[k], 1'b1);
      check($sformatf("rst/d%0d/read_n", k), avm_read_n[k], 1'b1);
      check($sformatf("rst/d%0d/addr", k), avm_address[k], 2'd0);
      check($sformatf("rst/d%0d/wdata", k), avm_writedata[k], 32'd0);
      check($sformatf("rst/d%0d/rsp_valid", k), rsp_valid[k], 1'b0);
      check($sformatf("rst/d%0d/rdata", k), rsp_readdata[k], 32'd0);
      check($sformatf("rst/d%0d/err", k), rsp_error[k], 1'b0);
      check($sformatf("rst/d%0d/slave_mem3", k), slv_mem[k][3], 32'd0);
    end
    reset = 1'b0; cmd_valid = 1'b0;

    // directed accesses
    run_cmd(1'b1, 2'd0, 32'hDEADBEEF, 1'b0, 0, "wr0");
    run_cmd(1'b0, 2'd0, 32'h0, 1'b1, 0, "rd0_hold");
    run_cmd(1'b0, 2'd1, 32'h0, 1'b1, 0, "rd1_hold");
    run_cmd(1'b1, 2'd2, 32'h12345678, 1'b0, 0, "wr2");
    run_cmd(1'b0, 2'd2, 32'h0, 1'b0, 0, "rd2_lat");
`ifdef AVM_WAITREQUEST_EN
    run_cmd(1'b0, 2'd0, 32'h0, 1'b0, 3, "rd_stall3");
    run_cmd(1'b0, 2'd0, 32'h0, 1'b0, 1000, "rd_timeout");
    run_cmd(1'b1, 2'd1, 32'hCAFE_F00D, 1'b0, 1000, "wr_timeout");
    run_cmd(1'b1, 2'd1, 32'h0BAD_CAFE, 1'b0, TMO - 1, "wr_stall_edge");
`endif

    // reset while the strobe is up
    @(negedge clk);
    stall_cfg = 0;
    clear_stats();
    cur_wr = 1'b0; cur_addr = 2'd1; t0 = cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) check($sformatf("rst_acc/d%0d/cs_up", k), avm_chipselect[k], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_acc/d%0d/cs", k), avm_chipselect[k], 1'b0);
      check($sformatf("rst_acc/d%0d/read_n", k), avm_read_n[k], 1'b1);
      check($sformatf("rst_acc/d%0d/rsp_valid", k), rsp_valid[k], 1'b0);
      check($sformatf("rst_acc/d%0d/rdata", k), rsp_readdata[k], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("rst_acc/d%0d/ready", k), cmd_ready[k], 1'b1);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("rst_acc/d%0d/no_rsp", k), rsp_cnt[k], 0);

    // random traffic
    for (int i = 0; i < 24; i++)
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 10), $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
